// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution over raster-ordered multi-channel pixels.
// Each channel has its own kernel, and the per-channel results are summed into one shifted, saturated output.
module conv3x3_stream_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int NUM_CH     = 3,
    parameter int MAX_W      = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        cfg_img_w,
    input  logic [ADDR_WIDTH-1:0]        cfg_img_h,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_relu,
    input  logic                         knl_wr_en,
    input  logic [ADDR_WIDTH-1:0]        knl_wr_addr,
    input  logic [COEF_WIDTH-1:0]        knl_wr_data,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] pix_data,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [OUT_WIDTH-1:0]         res_data,
    output logic                         res_last,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);
    localparam int NTAP   = 9 * NUM_CH;
    localparam int PIX_W  = NUM_CH * DATA_WIDTH;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + $clog2(9 * NUM_CH) + 1;
    localparam int COL_W  = $clog2(MAX_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH:0]      MAX_W_C = (ADDR_WIDTH + 1)'(MAX_W);
    localparam logic signed [ACC_W-1:0] SMAX    = ACC_W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN    = ~SMAX;
    localparam logic signed [ACC_W-1:0] UMAX    = ACC_W'((2 ** OUT_WIDTH) - 1);

    logic [1:0]                   state;
    logic [ADDR_WIDTH-1:0]        img_w, img_h, col, row;
    logic [4:0]                   shift;
    logic                         relu;
    logic signed [COEF_WIDTH-1:0] kernel [NTAP];
    logic [PIX_W-1:0]             line0 [MAX_W];
    logic [PIX_W-1:0]             line1 [MAX_W];
    logic [PIX_W-1:0]             win  [3][3];
    logic [PIX_W-1:0]             nwin [3][3];
    logic signed [PROD_W-1:0]     prod [NTAP];
    logic                         s1_valid, s1_last;
    logic signed [ACC_W-1:0]      acc_sum, acc_shift;
    logic [OUT_WIDTH-1:0]         sat_val;
    logic                         pipe_en, pix_acc, last_pix, win_ok, cfg_ok;
    logic [COL_W-1:0]             col_idx;

    assign pipe_en   = !res_valid || res_ready;
    assign pix_ready = (state == ST_RUN) && pipe_en;
    assign pix_acc   = pix_valid && pix_ready;
    assign last_pix  = (col == img_w - ADDR_WIDTH'(1)) && (row == img_h - ADDR_WIDTH'(1));
    assign win_ok    = (row >= ADDR_WIDTH'(2)) && (col >= ADDR_WIDTH'(2));
    assign cfg_ok    = (cfg_img_w >= ADDR_WIDTH'(3)) && ({1'b0, cfg_img_w} <= MAX_W_C) &&
                       (cfg_img_h >= ADDR_WIDTH'(3));
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign col_idx   = col[COL_W-1:0];

    // The window seen by stage 1 already includes the incoming column, so products register on the accept edge.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                nwin[r][c] = win[r][c+1];
            end
        end
        nwin[0][2] = line1[col_idx];
        nwin[1][2] = line0[col_idx];
        nwin[2][2] = pix_data;
    end

    always_ff @(posedge clk) begin
        if (pix_acc) begin
            line1[col_idx] <= line0[col_idx];
            line0[col_idx] <= pix_data;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= nwin[r][c];
                end
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int t = 0; t < 9; t++) begin
                    prod[ch*9+t] <= PROD_W'($signed({1'b0, nwin[t/3][t%3][ch*DATA_WIDTH +: DATA_WIDTH]}))
                                  * PROD_W'(kernel[ch*9+t]);
                end
            end
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < NTAP; i++) begin
            acc_sum = acc_sum + ACC_W'(prod[i]);
        end
        acc_shift = acc_sum >>> shift;
        if (relu) begin
            if (acc_shift[ACC_W-1])     sat_val = '0;
            else if (acc_shift > UMAX)  sat_val = '1;
            else                        sat_val = acc_shift[OUT_WIDTH-1:0];
        end else begin
            if (acc_shift > SMAX)       sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            else if (acc_shift < SMIN)  sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            else                        sat_val = acc_shift[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            img_w     <= '0;
            img_h     <= '0;
            col       <= '0;
            row       <= '0;
            shift     <= '0;
            relu      <= 1'b0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_data  <= '0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < NTAP; i++) kernel[i] <= '0;
        end else begin
            cfg_err <= 1'b0;
            if (state == ST_IDLE && knl_wr_en) begin
                for (int i = 0; i < NTAP; i++) begin
                    if (knl_wr_addr == ADDR_WIDTH'(i)) kernel[i] <= knl_wr_data;
                end
            end
            if (abort) begin
                state     <= ST_IDLE;
                s1_valid  <= 1'b0;
                s1_last   <= 1'b0;
                res_valid <= 1'b0;
                res_last  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && cfg_ok) begin
                            img_w <= cfg_img_w;
                            img_h <= cfg_img_h;
                            shift <= cfg_shift;
                            relu  <= cfg_relu;
                            col   <= '0;
                            row   <= '0;
                            state <= ST_RUN;
                        end else if (start) begin
                            cfg_err <= 1'b1;
                        end
                    end
                    ST_RUN:   if (pix_acc && last_pix) state <= ST_DRAIN;
                    ST_DRAIN: if (res_valid && res_ready && res_last) state <= ST_DONE;
                    default:  state <= ST_IDLE;
                endcase
                if (pix_acc) begin
                    if (col == img_w - ADDR_WIDTH'(1)) begin
                        col <= '0;
                        row <= row + ADDR_WIDTH'(1);
                    end else begin
                        col <= col + ADDR_WIDTH'(1);
                    end
                end
                if (pipe_en) begin
                    s1_valid  <= pix_acc && win_ok;
                    s1_last   <= pix_acc && last_pix;
                    res_valid <= s1_valid;
                    res_last  <= s1_last;
                    if (s1_valid) res_data <= sat_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Directed + randomized bench for conv3x3_stream_engine.
// Expected results come from an image-level convolution model over the stored frame and kernel arrays.
module tb_conv3x3_stream_engine;
    localparam int NUM_CH = 3;
    localparam int NTAP   = 27;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_img_w, cfg_img_h;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic        knl_wr_en;
    logic [7:0]  knl_wr_addr;
    logic [7:0]  knl_wr_data;
    logic        start, abort;
    logic        pix_valid, pix_ready;
    logic [23:0] pix_data;
    logic        res_valid, res_ready;
    logic [7:0]  res_data;
    logic        res_last, busy, done, cfg_err;

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] img [64*64];
    int          kmod [NTAP];

    always #5 clk = ~clk;

    conv3x3_stream_engine #(
        .DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_CH(NUM_CH),
        .MAX_W(64), .ADDR_WIDTH(8), .OUT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .knl_wr_en(knl_wr_en), .knl_wr_addr(knl_wr_addr), .knl_wr_data(knl_wr_data),
        .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic write_kernel(input int addr, input int data);
        @(negedge clk);
        knl_wr_en   = 1'b1;
        knl_wr_addr = 8'(addr);
        knl_wr_data = 8'(data);
        @(negedge clk);
        knl_wr_en   = 1'b0;
    endtask

    task automatic load_kernel();
        for (int i = 0; i < NTAP; i++) write_kernel(i, kmod[i]);
    endtask

    // Valid-mode convolution result for the window whose bottom-right pixel is (r, c).
    function automatic int model_result(input int w, input int r, input int c, input int sh, input int relu);
        int acc = 0;
        int px;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int kr = 0; kr < 3; kr++)
                for (int kc = 0; kc < 3; kc++) begin
                    px  = int'((img[(r-2+kr)*w + (c-2+kc)] >> (ch*8)) & 24'hFF);
                    acc += px * kmod[ch*9 + kr*3 + kc];
                end
        acc = acc >>> sh;
        if (relu != 0) acc = (acc < 0) ? 0 : (acc > 255) ? 255 : acc;
        else           acc = (acc < -128) ? -128 : (acc > 127) ? 127 : acc;
        return acc & 255;
    endfunction

    // cut_kind 0 = abort, 1 = reset; applied once cut_at pixels have been accepted.
    task automatic apply_stimulus(input int w, input int h, input int sh, input int relu,
                                  input int rand_ready, input int stall_at,
                                  input int cut_at, input int cut_kind,
                                  input int wr_addr, input int wr_data);
        int exp_q[$];
        int p, got, cyc, done_cnt, stall_idx;
        logic [7:0] held;
        bit stalling;
        if (wr_addr >= 0) kmod[wr_addr] = wr_data;
        for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++) exp_q.push_back(model_result(w, r, c, sh, relu));

        @(negedge clk);
        cfg_img_w = 8'(w);
        cfg_img_h = 8'(h);
        cfg_shift = 5'(sh);
        cfg_relu  = (relu != 0);
        start     = 1'b1;
        if (wr_addr >= 0) begin
            knl_wr_en   = 1'b1;
            knl_wr_addr = 8'(wr_addr);
            knl_wr_data = 8'(wr_data);
        end
        @(negedge clk);
        start     = 1'b0;
        knl_wr_en = 1'b0;

        p = 0; got = 0; cyc = 0; done_cnt = 0; stall_idx = -1; held = '0;
        while (cyc < w*h*4 + 200 && !(got == exp_q.size() && done_cnt > 0)) begin
            if (cut_at >= 0 && p == cut_at) begin
                pix_valid = 1'b0;
                res_ready = 1'b1;
                if (cut_kind == 0) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    #1;
                    check_output("abort_busy", 32'(busy), 0);
                    check_output("abort_res_valid", 32'(res_valid), 0);
                    check_output("abort_pix_ready", 32'(pix_ready), 0);
                end else begin
                    rst = 1'b1;
                    #1;
                    check_output("rst_busy", 32'(busy), 0);
                    check_output("rst_res_valid", 32'(res_valid), 0);
                    check_output("rst_res_data", 32'(res_data), 0);
                    check_output("rst_res_last", 32'(res_last), 0);
                    check_output("rst_pix_ready", 32'(pix_ready), 0);
                    @(negedge clk);
                    rst = 1'b0;
                end
                done_cnt = 0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    #1;
                    if (done) done_cnt++;
                end
                check_output("no_done_after_cut", 32'(done_cnt), 0);
                return;
            end
            if (stall_at >= 0 && got == stall_at && stall_idx < 0) stall_idx = 0;
            stalling  = (stall_idx >= 0) && (stall_idx < 10);
            res_ready = stalling ? 1'b0 : (rand_ready != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_valid = (p < w*h);
            pix_data  = pix_valid ? img[p] : '0;
            #1;
            if (stalling && stall_idx >= 2) begin
                check_output("stall_pix_ready", 32'(pix_ready), 0);
                check_output("stall_res_valid", 32'(res_valid), 1);
                if (stall_idx == 2) held = res_data;
                else check_output("stall_res_hold", 32'(res_data), 32'(held));
            end
            if (pix_valid && pix_ready) p++;
            if (res_valid && res_ready) begin
                if (got < exp_q.size()) begin
                    check_output($sformatf("res_data[%0d]", got), 32'(res_data), 32'(exp_q[got]));
                    check_output($sformatf("res_last[%0d]", got), 32'(res_last),
                                 32'(got == exp_q.size() - 1));
                end else begin
                    check_output("extra_result", 32'(got), 32'(exp_q.size()));
                end
                got++;
            end
            if (done) done_cnt++;
            if (stall_idx >= 0) stall_idx++;
            cyc++;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        res_ready = 1'b1;
        check_output("frame_complete", 32'(got == exp_q.size() && done_cnt > 0), 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            if (done) done_cnt++;
            @(negedge clk);
        end
        check_output("done_once", 32'(done_cnt), 1);
        check_output("idle_after_frame", 32'(busy), 0);
    endtask

    initial begin
        int bad_w[3] = '{2, 65, 8};
        int bad_h[3] = '{4, 4, 2};
        rst = 1'b1;
        cfg_img_w = '0; cfg_img_h = '0; cfg_shift = '0; cfg_relu = 1'b0;
        knl_wr_en = 1'b0; knl_wr_addr = '0; knl_wr_data = '0;
        start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = '0; res_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check_output("reset_pix_ready", 32'(pix_ready), 0);
        check_output("reset_res_valid", 32'(res_valid), 0);
        check_output("reset_res_data", 32'(res_data), 0);
        check_output("reset_res_last", 32'(res_last), 0);
        check_output("reset_busy", 32'(busy), 0);
        check_output("reset_done", 32'(done), 0);
        check_output("reset_cfg_err", 32'(cfg_err), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] T1 identity");
        foreach (kmod[i]) kmod[i] = 0;
        kmod[4] = 1;
        load_kernel();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img[r*4+c] = {16'($urandom), 8'(r*4+c)};
        apply_stimulus(4, 4, 0, 0, 0, -1, -1, 0, -1, 0);

        $display("[TB] T2 sum/saturate");
        foreach (kmod[i]) kmod[i] = 1;
        load_kernel();
        for (int i = 0; i < 9; i++) img[i] = 24'h0A0A0A;
        apply_stimulus(3, 3, 2, 0, 0, -1, -1, 0, -1, 0);
        apply_stimulus(3, 3, 0, 0, 0, -1, -1, 0, -1, 0);

        $display("[TB] T3 sign");
        foreach (kmod[i]) kmod[i] = 0;
        kmod[4] = -1;
        load_kernel();
        for (int i = 0; i < 9; i++) img[i] = 24'($urandom);
        img[4] = {16'($urandom), 8'd50};
        apply_stimulus(3, 3, 0, 0, 0, -1, -1, 0, -1, 0);
        apply_stimulus(3, 3, 0, 1, 0, -1, -1, 0, -1, 0);

        $display("[TB] T4 backpressure, kernel write alongside start");
        foreach (kmod[i]) kmod[i] = int'($urandom_range(0, 15)) - 8;
        kmod[26] = 0;
        load_kernel();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) img[r*8+c] = {8'(r*8+c+2), 8'(r*8+c+1), 8'(r*8+c)};
        apply_stimulus(8, 8, 3, 0, 0, 10, -1, 0, 26, 5);

        $display("[TB] T5 config");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cfg_img_w = 8'(bad_w[k]);
            cfg_img_h = 8'(bad_h[k]);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            check_output($sformatf("cfg_err_pulse[%0d]", k), 32'(cfg_err), 1);
            check_output($sformatf("cfg_err_busy[%0d]", k), 32'(busy), 0);
            @(negedge clk);
            #1;
            check_output($sformatf("cfg_err_clear[%0d]", k), 32'(cfg_err), 0);
        end
        foreach (kmod[i]) kmod[i] = int'($urandom_range(0, 255)) - 128;
        load_kernel();
        for (int i = 0; i < 64*4; i++) img[i] = 24'($urandom);
        apply_stimulus(64, 4, 9, 0, 1, -1, -1, 0, -1, 0);

        $display("[TB] T6 abort and reset");
        foreach (kmod[i]) kmod[i] = int'($urandom_range(0, 31)) - 16;
        load_kernel();
        for (int i = 0; i < 36; i++) img[i] = 24'($urandom);
        apply_stimulus(6, 6, 6, 0, 0, -1, 20, 0, -1, 0);
        apply_stimulus(6, 6, 6, 0, 1, -1, -1, 0, -1, 0);
        apply_stimulus(6, 6, 6, 0, 0, -1, 20, 1, -1, 0);
        foreach (kmod[i]) kmod[i] = 0;
        for (int i = 0; i < 9; i++) img[i] = 24'($urandom);
        apply_stimulus(3, 3, 0, 0, 0, -1, -1, 0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
